// File: rtl/oled_pkg.sv
// oled_pkg
// Shared definitions for the OLED SPI responder: geometry defaults,
// SSD1306 opcodes, addressing-mode and decoder-state enums, and a helper
// that maps the memory-mode argument onto an addressing mode.
package oled_pkg;

  localparam int COLS_DEF  = 128;
  localparam int PAGES_DEF = 8;

  localparam logic [7:0] CONTRAST_RST = 8'h7F;

  // Opcodes followed by one argument byte
  localparam logic [7:0] OP_MEM_MODE    = 8'h20;
  localparam logic [7:0] OP_CONTRAST    = 8'h81;
  localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
  localparam logic [7:0] OP_DISP_OFFSET = 8'hD3;
  localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
  localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
  localparam logic [7:0] OP_COM_PINS    = 8'hDA;
  localparam logic [7:0] OP_VCOMH       = 8'hDB;

  // Opcodes followed by two argument bytes (start, end)
  localparam logic [7:0] OP_COL_ADDR    = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR   = 8'h22;

  // Single-byte opcodes
  localparam logic [7:0] OP_DISP_OFF    = 8'hAE;
  localparam logic [7:0] OP_DISP_ON     = 8'hAF;
  localparam logic [7:0] OP_ENTIRE_OFF  = 8'hA4;
  localparam logic [7:0] OP_ENTIRE_ON   = 8'hA5;
  localparam logic [7:0] OP_NORMAL      = 8'hA6;
  localparam logic [7:0] OP_INVERT      = 8'hA7;
  localparam logic [7:0] OP_SEG_REMAP0  = 8'hA0;
  localparam logic [7:0] OP_SEG_REMAP1  = 8'hA1;
  localparam logic [7:0] OP_COM_INC     = 8'hC0;
  localparam logic [7:0] OP_COM_DEC     = 8'hC8;

  typedef enum logic [1:0] {
    HORIZ = 2'd0,
    VERT  = 2'd1,
    PAGE  = 2'd2
  } addr_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARG1 = 2'd1,
    ST_ARG2 = 2'd2
  } dec_state_e;

  // Argument value 3 is reserved on the panel; treat it as page mode.
  function automatic addr_mode_e mode_from_arg(input logic [1:0] arg);
    addr_mode_e m;
    case (arg)
      2'd0:    m = HORIZ;
      2'd1:    m = VERT;
      default: m = PAGE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/oled_spi_deser.sv
// oled_spi_deser
// Oversampling front end of the OLED link. Synchronises the five link
// inputs into clk, detects rising SCK edges and shifts MOSI in MSB-first.
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   spi_sck/mosi/dc/cs/reset  raw link inputs (cs and reset active-low)
//   byte_valid                one-cycle pulse per completed byte
//   byte_data, byte_is_data   received byte and the DC level seen at bit 0
//   link_rst                  synchronised display reset (active-high)
module oled_spi_deser import oled_pkg::*; #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  input  logic       spi_cs,
  input  logic       spi_reset,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data,
  output logic       link_rst
);

  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, dc_sync, cs_sync, rstn_sync;
  logic                   sck_s, mosi_s, dc_s, cs_s;
  logic                   sck_prev;
  logic                   sck_rise;
  logic [2:0]             bit_cnt;
  logic [6:0]             shreg;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign dc_s     = dc_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign link_rst = ~rstn_sync[SYNC_STAGES-1];
  assign sck_rise = ~sck_prev & sck_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Idle levels, so leaving reset never looks like an SCK edge or a
      // display reset.
      sck_sync     <= '1;
      mosi_sync    <= '0;
      dc_sync      <= '0;
      cs_sync      <= '1;
      rstn_sync    <= '1;
      sck_prev     <= 1'b1;
      bit_cnt      <= 3'd7;
      shreg        <= '0;
      byte_valid   <= 1'b0;
      byte_data    <= '0;
      byte_is_data <= 1'b0;
    end else begin
      // Shift in at the LSB; the cast drops the oldest sample off the top.
      sck_sync  <= SYNC_STAGES'({sck_sync,  spi_sck});
      mosi_sync <= SYNC_STAGES'({mosi_sync, spi_mosi});
      dc_sync   <= SYNC_STAGES'({dc_sync,   spi_dc});
      cs_sync   <= SYNC_STAGES'({cs_sync,   spi_cs});
      rstn_sync <= SYNC_STAGES'({rstn_sync, spi_reset});
      sck_prev  <= sck_s;

      if (link_rst) begin
        bit_cnt      <= 3'd7;
        shreg        <= '0;
        byte_valid   <= 1'b0;
        byte_data    <= '0;
        byte_is_data <= 1'b0;
      end else begin
        byte_valid <= 1'b0;
        if (cs_s) begin
          bit_cnt <= 3'd7;
        end else if (sck_rise) begin
          shreg <= {shreg[5:0], mosi_s};
          if (bit_cnt == 3'd0) begin
            byte_valid   <= 1'b1;
            byte_data    <= {shreg, mosi_s};
            byte_is_data <= dc_s;
            bit_cnt      <= 3'd7;
          end else begin
            bit_cnt <= bit_cnt - 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/oled_spi_rx.sv
// oled_spi_rx
// Display side of the 4-wire SSD1306-style OLED SPI link. Decodes the
// command stream into display state and turns GDDRAM data bytes into
// framebuffer write strobes.
// Ports:
//   clk, rst                    system clock, synchronous active-high reset
//   spi_sck/mosi/dc/cs/reset    link inputs (cs and reset active-low)
//   byte_valid/data/is_data     raw received-byte stream
//   fb_we, fb_addr, fb_wdata    framebuffer write (addr = page*COLS + col)
//   display_on, contrast,
//   invert, cmd_error           decoded display state (cmd_error sticky)
//
// Decoder states:
//   state   | meaning
//   IDLE    | expecting an opcode
//   ARG1    | expecting first argument of cur_op
//   ARG2    | expecting second argument of 0x21 / 0x22
//
// Page-mode column nibble commands assume 32 <= COLS <= 256.
module oled_spi_rx import oled_pkg::*; #(
  parameter int COLS        = COLS_DEF,
  parameter int PAGES       = PAGES_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           spi_sck,
  input  logic                           spi_mosi,
  input  logic                           spi_dc,
  input  logic                           spi_cs,
  input  logic                           spi_reset,
  output logic                           byte_valid,
  output logic [7:0]                     byte_data,
  output logic                           byte_is_data,
  output logic                           fb_we,
  output logic [$clog2(COLS*PAGES)-1:0]  fb_addr,
  output logic [7:0]                     fb_wdata,
  output logic                           display_on,
  output logic [7:0]                     contrast,
  output logic                           invert,
  output logic                           cmd_error
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);
  localparam int AW = $clog2(COLS*PAGES);

  logic          link_rst;
  dec_state_e    state;
  logic [7:0]    cur_op;
  addr_mode_e    addr_mode;
  logic [CW-1:0] col, col_start, col_end;
  logic [PW-1:0] page, page_start, page_end;
  logic [CW-1:0] col_inc, col_nxt, col_lo, col_hi;
  logic [PW-1:0] page_inc, page_nxt;

  oled_spi_deser #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_deser (
    .clk          (clk),
    .rst          (rst),
    .spi_sck      (spi_sck),
    .spi_mosi     (spi_mosi),
    .spi_dc       (spi_dc),
    .spi_cs       (spi_cs),
    .spi_reset    (spi_reset),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .link_rst     (link_rst)
  );

  // Pointer advance after a GDDRAM write, wrapping inside the window.
  always_comb begin
    col_inc  = (col == col_end) ? col_start : col + CW'(1);
    page_inc = (page == page_end) ? page_start : page + PW'(1);
    col_nxt  = col;
    page_nxt = page;
    case (addr_mode)
      HORIZ: begin
        col_nxt = col_inc;
        if (col == col_end) page_nxt = page_inc;
      end
      VERT: begin
        page_nxt = page_inc;
        if (page == page_end) col_nxt = col_inc;
      end
      default: col_nxt = col_inc;
    endcase
  end

  // Page-mode column pointer with one nibble replaced.
  assign col_lo = {col[CW-1:4], byte_data[3:0]};
  assign col_hi = {byte_data[CW-5:0], col[3:0]};

  always_ff @(posedge clk) begin
    if (rst || link_rst) begin
      state      <= ST_IDLE;
      cur_op     <= '0;
      addr_mode  <= PAGE;
      col        <= '0;
      col_start  <= '0;
      col_end    <= CW'(COLS - 1);
      page       <= '0;
      page_start <= '0;
      page_end   <= PW'(PAGES - 1);
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      display_on <= 1'b0;
      contrast   <= CONTRAST_RST;
      invert     <= 1'b0;
      cmd_error  <= 1'b0;
    end else begin
      fb_we <= 1'b0;
      if (byte_valid && byte_is_data) begin
        // Data bytes never move the decoder, even mid-argument.
        fb_we    <= 1'b1;
        fb_addr  <= AW'(page) * AW'(COLS) + AW'(col);
        fb_wdata <= byte_data;
        col      <= col_nxt;
        page     <= page_nxt;
      end else if (byte_valid) begin
        case (state)
          ST_IDLE: begin
            case (byte_data) inside
              OP_DISP_OFF: display_on <= 1'b0;
              OP_DISP_ON:  display_on <= 1'b1;
              OP_NORMAL:   invert     <= 1'b0;
              OP_INVERT:   invert     <= 1'b1;
              // Accepted but with no effect on the mirrored state.
              OP_ENTIRE_OFF, OP_ENTIRE_ON, OP_SEG_REMAP0, OP_SEG_REMAP1,
              OP_COM_INC, OP_COM_DEC, [8'h40:8'h7F]: ;
              [8'hB0:8'hB7]: page <= PW'(byte_data[2:0]);
              [8'h00:8'h0F]: col  <= col_lo;
              [8'h10:8'h1F]: col  <= col_hi;
              OP_MEM_MODE, OP_CONTRAST, OP_CHARGE_PUMP, OP_MUX_RATIO,
              OP_DISP_OFFSET, OP_CLK_DIV, OP_PRECHARGE, OP_COM_PINS,
              OP_VCOMH, OP_COL_ADDR, OP_PAGE_ADDR: begin
                cur_op <= byte_data;
                state  <= ST_ARG1;
              end
              default: cmd_error <= 1'b1;
            endcase
          end
          ST_ARG1: begin
            state <= ST_IDLE;
            case (cur_op)
              OP_MEM_MODE: addr_mode <= mode_from_arg(byte_data[1:0]);
              OP_CONTRAST: contrast  <= byte_data;
              OP_COL_ADDR: begin
                col_start <= byte_data[CW-1:0];
                col       <= byte_data[CW-1:0];
                state     <= ST_ARG2;
              end
              OP_PAGE_ADDR: begin
                page_start <= byte_data[PW-1:0];
                page       <= byte_data[PW-1:0];
                state      <= ST_ARG2;
              end
              default: ;
            endcase
          end
          ST_ARG2: begin
            state <= ST_IDLE;
            if (cur_op == OP_COL_ADDR) col_end  <= byte_data[CW-1:0];
            else                       page_end <= byte_data[PW-1:0];
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
